// File: rtl/mask_arb_pkg.sv
// Shared types and defaults for the thresholded-mask BRAM read arbiter.
// Holds the default sizes, the response tag record and the arbiter state encoding.
package mask_arb_pkg;

  localparam int MASK_ADDR_WIDTH   = 19;
  localparam int MASK_READ_LATENCY = 2;
  localparam int NUM_MASK_REQ      = 2;

  typedef struct packed {
    logic                            valid;
    logic [$clog2(NUM_MASK_REQ)-1:0] id;
  } tag_t;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Requester index width; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first candidate at or after start_i, ascending with wrap.
// Candidates are the valid requesters not named in the exclude mask.
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] start_i,
  input  logic [N-1:0]  excl_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0] cand;

  assign cand = valid_i & ~excl_i;

  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    j       = 0;
    jj      = '0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(start_i) + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any_o && cand[jj]) begin
        any_o       = 1'b1;
        grant_o[jj] = 1'b1;
        idx_o       = jj;
      end
    end
  end

endmodule

// File: rtl/mask_bram_read_arbiter.sv
// Round-robin, burst-bounded arbiter for the mask BRAM read port with a tag pipeline
// that steers each read result back to its requester as a one-hot response valid.
module mask_bram_read_arbiter
  import mask_arb_pkg::*;
#(
  parameter int NUM_REQ      = NUM_MASK_REQ,
  parameter int ADDR_WIDTH   = MASK_ADDR_WIDTH,
  parameter int DATA_WIDTH   = 1,
  parameter int READ_LATENCY = MASK_READ_LATENCY,
  parameter int MAX_BURST    = 16,
  localparam int IW          = id_width(NUM_REQ),
  localparam int CW          = $clog2(MAX_BURST + 1)
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic [NUM_REQ-1:0]                 req_valid_in,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_in,
  output logic [NUM_REQ-1:0]                 req_ready_out,
  output logic [NUM_REQ-1:0]                 rsp_valid_out,
  output logic [DATA_WIDTH-1:0]              rsp_data_out,
  output logic [ADDR_WIDTH-1:0]              bram_addr_out,
  output logic                               bram_en_out,
  input  logic [DATA_WIDTH-1:0]              bram_data_in,
  output logic                               busy_out,
  output arb_state_t                         dbg_state_out,
  output logic [IW-1:0]                      dbg_owner_out,
  output logic [IW-1:0]                      dbg_rr_ptr_out,
  output logic [CW-1:0]                      dbg_burst_cnt_out
);

  // Handshake: a read transfers on a clk_in edge where req_valid_in[i] and
  // req_ready_out[i] are both high; ready is one-hot and may fall with valid.

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
  } tag_w_t;

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   burst_q, burst_d;
  logic [IW-1:0]   owner_nxt, pick_start, pick_idx;
  logic [NUM_REQ-1:0] owner_oh, pick_excl, pick_grant, grant;
  logic            pick_any, owner_valid, others_valid, accept, inflight;
  logic [ADDR_WIDTH-1:0] bram_addr_q;
  logic            bram_en_q;
  tag_w_t          tag_q [READ_LATENCY+1];

  assign owner_oh     = NUM_REQ'(1) << owner_q;
  assign owner_nxt    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign owner_valid  = |(req_valid_in & owner_oh);
  assign others_valid = |(req_valid_in & ~owner_oh);

  // Once owned, any rearbitration starts after the owner and skips it.
  assign pick_start = (state_q == OWN) ? owner_nxt : rr_ptr_q;
  assign pick_excl  = (state_q == OWN) ? owner_oh : '0;

  rr_priority_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .valid_i (req_valid_in),
    .start_i (pick_start),
    .excl_i  (pick_excl),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    grant    = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = OWN;
          owner_d = pick_idx;
          burst_d = CW'(1);
          grant   = pick_grant;
        end
      end
      default: begin
        if (owner_valid && ((burst_q < CW'(MAX_BURST)) || !others_valid)) begin
          grant   = owner_oh;
          burst_d = (burst_q == CW'(MAX_BURST)) ? burst_q : burst_q + 1'b1;
        end else begin
          rr_ptr_d = owner_nxt;
          if (pick_any) begin
            owner_d = pick_idx;
            burst_d = CW'(1);
            grant   = pick_grant;
          end else begin
            state_d = IDLE;
            burst_d = '0;
          end
        end
      end
    endcase
  end

  assign accept = |grant;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_q     <= '0;
      bram_addr_q <= '0;
      bram_en_q   <= 1'b0;
      for (int i = 0; i <= READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      burst_q   <= burst_d;
      bram_en_q <= accept;
      if (accept) bram_addr_q <= req_addr_in[owner_d];
      tag_q[0] <= '{valid: accept, id: owner_d};
      for (int i = 1; i <= READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i <= READ_LATENCY; i++) inflight = inflight | tag_q[i].valid;
  end

  // Gating with reset keeps the combinational outputs quiet while held in reset.
  assign req_ready_out     = grant & {NUM_REQ{rst_n_in}};
  assign busy_out          = rst_n_in & ((|req_valid_in) | inflight);
  assign rsp_valid_out     = tag_q[READ_LATENCY].valid ?
                             (NUM_REQ'(1) << tag_q[READ_LATENCY].id) : '0;
  assign rsp_data_out      = bram_data_in;
  assign bram_addr_out     = bram_addr_q;
  assign bram_en_out       = bram_en_q;
  assign dbg_state_out     = state_q;
  assign dbg_owner_out     = owner_q;
  assign dbg_rr_ptr_out    = rr_ptr_q;
  assign dbg_burst_cnt_out = burst_q;

endmodule
